instruction_transmitter: RTL and testbench

- Serializing transmitter for the two-wire instruction link (set_bit strobe plus input_bit data) that carries 11-bit servo instruction words into the FPGA controller.
- Accepts one parallel word per valid/ready handshake. Shifts it out MSB first, with input_bit stable around each set_bit rising edge, then inserts an idle gap.
- Used as the bench/host-side driver and as the loop-back path for self-test.
- Payload is transparent to this block. Field layout: [10] activation, [9] maintenance mode, [8] servo select, [7:0] position value.

---
 rtl/instruction_transmitter_if.sv | 20 ++
 rtl/instruction_transmitter.sv | 120 ++++++++++++
 tb/tb_instruction_transmitter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_transmitter_if.sv
// Parallel word handshake into the instruction link serializer.
interface instruction_transmitter_if #(
    parameter int WORD_WIDTH = 11
);
    logic                  tx_valid;
    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/instruction_transmitter.sv
// Two-wire instruction link transmitter: set_bit strobe plus input_bit data,
// MSB first, followed by an idle gap before the next word is accepted.
module instruction_transmitter #(
    parameter int WORD_WIDTH    = 11,
    parameter int CLKS_PER_HALF = 4,
    parameter int GAP_CLKS      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instruction_transmitter_if.slave tx,
    output logic                   busy,
    output logic                   done,
    output logic                   set_bit,
    output logic                   input_bit
);
    localparam int MAX_CNT = (CLKS_PER_HALF > GAP_CLKS) ?
                             CLKS_PER_HALF : GAP_CLKS;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam int IW = $clog2(WORD_WIDTH);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CLKS - 1);
    localparam logic [IW-1:0] IDX_TOP   = IW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic [WORD_WIDTH-1:0] shreg, shreg_n;
    logic                  ready_q, ready_n;
    logic                  done_n, set_bit_n, input_bit_n;

    assign tx.tx_ready = ready_q;
    assign busy        = !ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            ready_q   <= 1'b1;
            done      <= 1'b0;
            set_bit   <= 1'b0;
            input_bit <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            ready_q   <= ready_n;
            done      <= done_n;
            set_bit   <= set_bit_n;
            input_bit <= input_bit_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (tx.tx_valid) begin
                    shreg_n = tx.tx_data;
                    idx_n   = IDX_TOP;
                    cnt_n   = '0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = STROBE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STROBE: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (idx != '0) begin
                        idx_n   = idx - IW'(1);
                        shreg_n = {shreg[WORD_WIDTH-2:0], 1'b0};
                        state_n = SETUP;
                    end else begin
                        state_n = GAP;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase

        // Outputs are registered copies of the next-state view, so the new
        // bit lands on input_bit in the same cycle set_bit falls.
        ready_n     = (state_n == IDLE);
        set_bit_n   = (state_n == STROBE);
        input_bit_n = (state_n == SETUP || state_n == STROBE) ?
                      shreg_n[WORD_WIDTH-1] : 1'b0;
    end
endmodule

// File: tb/tb_instruction_transmitter.sv
// Bench for instruction_transmitter: default and fast-parameter instances
// checked cycle by cycle against a frame-timing model and a strobe receiver.
module tb_instruction_transmitter;
    localparam int W  = 11;
    localparam int H  = 4;
    localparam int G  = 8;
    localparam int FH = 1;
    localparam int FG = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    instruction_transmitter_if #(.WORD_WIDTH(W)) bus ();
    instruction_transmitter_if #(.WORD_WIDTH(W)) fbus ();

    logic busy, done, set_bit, input_bit;
    logic f_busy, f_done, f_set_bit, f_input_bit;

    instruction_transmitter #(
        .WORD_WIDTH(W), .CLKS_PER_HALF(H), .GAP_CLKS(G)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .tx(bus),
        .busy(busy), .done(done),
        .set_bit(set_bit), .input_bit(input_bit)
    );

    instruction_transmitter #(
        .WORD_WIDTH(W), .CLKS_PER_HALF(FH), .GAP_CLKS(FG)
    ) u_fast (
        .clk(clk), .rst_n(rst_n), .tx(fbus),
        .busy(f_busy), .done(f_done),
        .set_bit(f_set_bit), .input_bit(f_input_bit)
    );

    int vectors = 0;
    int errors  = 0;

    // Receiver models: capture input_bit on each set_bit rising edge.
    logic [W-1:0] rx_word   = '0;
    logic [W-1:0] f_rx_word = '0;
    int rx_edges   = 0;
    int f_rx_edges = 0;

    always @(posedge set_bit) begin
        rx_word = {rx_word[W-2:0], input_bit};
        rx_edges++;
    end

    always @(posedge f_set_bit) begin
        f_rx_word = {f_rx_word[W-2:0], f_input_bit};
        f_rx_edges++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs,
                           input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic drive(input bit fast, input logic v,
                         input logic [W-1:0] d);
        if (fast) begin
            fbus.tx_valid = v;
            fbus.tx_data  = d;
        end else begin
            bus.tx_valid = v;
            bus.tx_data  = d;
        end
    endtask

    task automatic check_out(input bit fast, input logic es,
                             input logic ei, input logic er,
                             input logic ed);
        string pre;
        pre = fast ? "fast." : "dflt.";
        if (fast) begin
            chk_bit({pre, "set_bit"},   f_set_bit,     es);
            chk_bit({pre, "input_bit"}, f_input_bit,   ei);
            chk_bit({pre, "tx_ready"},  fbus.tx_ready, er);
            chk_bit({pre, "busy"},      f_busy,        !er);
            chk_bit({pre, "done"},      f_done,        ed);
        end else begin
            chk_bit({pre, "set_bit"},   set_bit,       es);
            chk_bit({pre, "input_bit"}, input_bit,     ei);
            chk_bit({pre, "tx_ready"},  bus.tx_ready,  er);
            chk_bit({pre, "busy"},      busy,          !er);
            chk_bit({pre, "done"},      done,          ed);
        end
    endtask

    // Called at a negedge with tx_ready high; accept happens at the next
    // posedge. Expected waveform is derived from the cycle offset alone.
    task automatic send_frame(input bit fast, input logic [W-1:0] word,
                              input bit rand_in, input logic next_v,
                              input logic [W-1:0] next_d);
        int h, g, half2, bits_end, total;
        h        = fast ? FH : H;
        g        = fast ? FG : G;
        half2    = 2 * h;
        bits_end = W * half2;
        total    = bits_end + g;
        if (fast) f_rx_edges = 0;
        else      rx_edges   = 0;
        drive(fast, 1'b1, word);
        @(posedge clk);
        for (int off = 0; off <= total; off++) begin
            @(negedge clk);
            if (off < bits_end)
                check_out(fast, ((off % half2) >= h),
                          word[W-1-off/half2], 1'b0, 1'b0);
            else if (off < total)
                check_out(fast, 1'b0, 1'b0, 1'b0, 1'b0);
            else
                check_out(fast, 1'b0, 1'b0, 1'b1, 1'b1);
            if (off == total - 1)
                drive(fast, next_v, next_d);
            else if (off < total - 1) begin
                if (rand_in) drive(fast, 1'($urandom), W'($urandom));
                else         drive(fast, 1'b0, word);
            end
        end
        if (fast) begin
            chk("fast.edges", f_rx_edges, W);
            chk("fast.rx_word", {21'b0, f_rx_word}, {21'b0, word});
        end else begin
            chk("dflt.edges", rx_edges, W);
            chk("dflt.rx_word", {21'b0, rx_word}, {21'b0, word});
        end
    endtask

    task automatic idle_both();
        check_out(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [W-1:0] w1, w2;
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);

        #1 rst_n = 1'b0;
        #2 idle_both();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            idle_both();
        end

        send_frame(1'b0, 11'h5A5, 1'b0, 1'b0, '0);
        @(negedge clk);
        check_out(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        send_frame(1'b0, 11'h7FF, 1'b0, 1'b1, 11'h000);
        send_frame(1'b0, 11'h000, 1'b0, 1'b0, '0);

        send_frame(1'b0, 11'h301, 1'b1, 1'b0, '0);
        @(negedge clk);
        check_out(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Abort a frame with reset while set_bit is high.
        drive(1'b0, 1'b1, 11'h155);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        repeat (39) @(negedge clk);
        chk_bit("dflt.pre_reset_set_bit", set_bit, 1'b1);
        #1 rst_n = 1'b0;
        #1 idle_both();
        repeat (4) begin
            @(negedge clk);
            idle_both();
        end
        rst_n = 1'b1;
        @(negedge clk);
        idle_both();
        send_frame(1'b0, 11'h4FF, 1'b0, 1'b0, '0);

        send_frame(1'b1, 11'h2AA, 1'b0, 1'b0, '0);
        @(negedge clk);
        check_out(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        w1 = W'($urandom);
        w2 = W'($urandom);
        send_frame(1'b1, w1, 1'b0, 1'b1, w2);
        send_frame(1'b1, w2, 1'b1, 1'b0, '0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            send_frame(1'(i % 2), W'($urandom), 1'b1, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
